floo_edge_err_responder: RTL and testbench
==========================================

Name: floo_edge_err_responder

Overview:
- Terminates an unused mesh-boundary port of the narrow NoC link; replaces the hard tie-off at that edge.
- Consumes any request flit that routes off the mesh edge (misrouted or unmapped address). Returns AXI-compliant DECERR responses to the originating node, so initiators never hang.
- Counts and records offenders for debug readout by the Cheshire tile.
- Single outstanding transaction; flat valid/ready ports, adapted to floo link structs by the instantiating tile.

Parameters:
- IdWidth, 6, node id width (x,y packed; 3+3 bits).
- AxiIdWidth, 4, AXI transaction id width.
- DataWidth, 64, narrow R data width; R data is always driven zero.
- CntWidth, 16, error counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  request flit valid.
- req_ready_o  out  1  request flit accepted when valid&&ready.
- req_ch_i  in  2  channel: 0=AW, 1=W, 2=AR, 3=reserved.
- req_src_id_i  in  IdWidth  originating node id.
- req_axi_id_i  in  AxiIdWidth  AXI id (AW/AR only).
- req_len_i  in  8  AXI burst length-1 (AR only).
- req_last_i  in  1  W last beat.
- rsp_valid_o  out  1  response flit valid.
- rsp_ready_i  in  1  response accepted.
- rsp_ch_o  out  1  0=B, 1=R.
- rsp_dst_id_o  out  IdWidth  destination = latched src id.
- rsp_axi_id_o  out  AxiIdWidth  latched AXI id.
- rsp_resp_o  out  2  always 2'b11 (DECERR) while valid.
- rsp_data_o  out  DataWidth  always zero.
- rsp_last_o  out  1  last R beat; 1 for B.
- clr_i  in  1  clear counter and sticky record.
- err_cnt_o  out  CntWidth  saturating count of accepted AW+AR.
- err_valid_o  out  1  sticky: an error has been recorded.
- err_src_o  out  IdWidth  src id of first recorded offender since clear.
- proto_err_o  out  1  sticky: W in Idle or reserved channel seen.

Behaviour:
- Reset: FSM=Idle. All outputs 0, except req_ready_o=1 (Idle).
- FSM states: Idle, WrData, WrResp, RdResp.
- Idle:
  - req_ready_o=1.
  - AW accepted: latch src/id, go to WrData.
  - AR accepted: latch src/id/len, clear beat counter, go to RdResp.
  - W or reserved accepted: dropped, set proto_err_o, stay in Idle.
- WrData:
  - req_ready_o=1; only W expected.
  - Each W is dropped. W with req_last_i=1 goes to WrResp.
  - AW/AR/reserved arriving here: accepted and dropped, set proto_err_o, stay in WrData.
- WrResp:
  - req_ready_o=0.
  - rsp_valid_o=1, ch=B, last=1.
  - On rsp_ready_i go to Idle.
- RdResp:
  - req_ready_o=0.
  - rsp_valid_o=1, ch=R; beat counter 0..len.
  - rsp_last_o=(cnt==len). Counter increments on each handshake.
  - Handshake on last beat goes to Idle.
- Latency: acceptance at cycle t gives first response valid at t+1. With rsp_ready_i held high, R beats are back-to-back; len=255 gives 256 beats.
- Response fields are stable while rsp_valid_o && !rsp_ready_i; valid never drops before handshake.
- Request acceptance and response never overlap; one transaction in flight.
- Counter:
  - +1 on each AW/AR accepted in Idle; saturates at all-ones, no wrap.
  - First increment with err_valid_o=0 sets err_valid_o and captures err_src_o; later offenders do not overwrite.
- clr_i: clears err_cnt_o, err_valid_o, err_src_o, proto_err_o.
- Same cycle as an increment, the increment wins: cnt=1, err_valid_o=1, src captured.
- clr_i does not affect the FSM.
- Reset mid-transaction: the response is abandoned, outputs return to reset values. The initiator-side reset is expected concurrently.

Decomposition:
- picobello_pkg gains:
  - edge_req_ch_e (AW, W, AR, Rsvd).
  - edge_rsp_ch_e (B, R).
  - localparam EdgeRespDecErr = 2'b11.
- Tile-level glue maps floo_req_t/floo_rsp_t fields to these ports.
- No sub-module; counter and FSM are inline.

Test Plan:
- AR src=0x12 id=3 len=3, rsp_ready_i=1 -> 4 R beats at t+1..t+4, dst=0x12, id=3, resp=3, last only on beat 4; err_cnt_o=1, err_src_o=0x12.
- AW id=5, three W beats (last on third), rsp_ready_i=0 for 5 cycles -> no B until W last; then one B held stable 5 cycles, resp=3, handshake returns to Idle.
- W flit while Idle -> accepted, proto_err_o=1, no response, err_cnt_o unchanged.
- 65537 AR len=0 with CntWidth=16 -> err_cnt_o saturates at 0xFFFF.
- clr_i in same cycle as AR acceptance, src=0x21 -> err_cnt_o=1, err_src_o=0x21, err_valid_o=1.
- rst_ni asserted mid R burst (beat 2 of 8) -> rsp_valid_o=0 immediately; after release, new AR len=0 yields a single correct R.

Source files
------------

// File: rtl/picobello_pkg.sv
// rtl/picobello_pkg.sv - shared edge-port channel encodings and constants
package picobello_pkg;

    typedef enum logic [1:0] {
        EdgeChAw   = 2'd0,
        EdgeChW    = 2'd1,
        EdgeChAr   = 2'd2,
        EdgeChRsvd = 2'd3
    } edge_req_ch_e;

    typedef enum logic {
        EdgeChB = 1'b0,
        EdgeChR = 1'b1
    } edge_rsp_ch_e;

    typedef enum logic [1:0] {
        EdgeStIdle   = 2'd0,
        EdgeStWrData = 2'd1,
        EdgeStWrResp = 2'd2,
        EdgeStRdResp = 2'd3
    } edge_state_e;

    localparam logic [1:0] EdgeRespDecErr = 2'b11;

endpackage

// File: rtl/floo_edge_err_responder.sv
// rtl/floo_edge_err_responder.sv - mesh-edge terminator answering every request with DECERR
module floo_edge_err_responder
    import picobello_pkg::*;
#(
    parameter int unsigned IdWidth    = 6,
    parameter int unsigned AxiIdWidth = 4,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_ch_i,
    input  logic [IdWidth-1:0]    req_src_id_i,
    input  logic [AxiIdWidth-1:0] req_axi_id_i,
    input  logic [7:0]            req_len_i,
    input  logic                  req_last_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_ch_o,
    output logic [IdWidth-1:0]    rsp_dst_id_o,
    output logic [AxiIdWidth-1:0] rsp_axi_id_o,
    output logic [1:0]            rsp_resp_o,
    output logic [DataWidth-1:0]  rsp_data_o,
    output logic                  rsp_last_o,
    input  logic                  clr_i,
    output logic [CntWidth-1:0]   err_cnt_o,
    output logic                  err_valid_o,
    output logic [IdWidth-1:0]    err_src_o,
    output logic                  proto_err_o
);

    edge_state_e           state_q, state_d;
    logic [IdWidth-1:0]    src_q, src_d;
    logic [AxiIdWidth-1:0] axi_id_q, axi_id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  err_valid_q, err_valid_d;
    logic [IdWidth-1:0]    err_src_q, err_src_d;
    logic                  proto_q, proto_d;

    edge_req_ch_e req_ch;
    logic         req_hs;
    logic         last_beat;
    logic         offender;
    logic         proto_hit;

    assign req_ch    = edge_req_ch_e'(req_ch_i);
    assign req_hs    = req_valid_i && req_ready_o;
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EdgeStIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EdgeStIdle: begin
                if (req_hs && req_ch == EdgeChAw) state_d = EdgeStWrData;
                if (req_hs && req_ch == EdgeChAr) state_d = EdgeStRdResp;
            end
            EdgeStWrData: begin
                if (req_hs && req_ch == EdgeChW && req_last_i) state_d = EdgeStWrResp;
            end
            EdgeStWrResp: begin
                if (rsp_ready_i) state_d = EdgeStIdle;
            end
            EdgeStRdResp: begin
                if (rsp_ready_i && last_beat) state_d = EdgeStIdle;
            end
            default: state_d = EdgeStIdle;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_ch_o    = EdgeChB;
        rsp_last_o  = 1'b0;
        case (state_q)
            EdgeStIdle, EdgeStWrData: req_ready_o = 1'b1;
            EdgeStWrResp: begin
                rsp_valid_o = 1'b1;
                rsp_last_o  = 1'b1;
            end
            EdgeStRdResp: begin
                rsp_valid_o = 1'b1;
                rsp_ch_o    = EdgeChR;
                rsp_last_o  = last_beat;
            end
            default: req_ready_o = 1'b0;
        endcase
    end

    assign rsp_dst_id_o = src_q;
    assign rsp_axi_id_o = axi_id_q;
    assign rsp_resp_o   = rsp_valid_o ? EdgeRespDecErr : 2'b00;
    assign rsp_data_o   = '0;

    // Only AW/AR taken in Idle count as offenders; stray flits are protocol errors.
    assign offender  = req_hs && (state_q == EdgeStIdle) &&
                       (req_ch == EdgeChAw || req_ch == EdgeChAr);
    assign proto_hit = req_hs &&
                       (((state_q == EdgeStIdle) && (req_ch == EdgeChW || req_ch == EdgeChRsvd)) ||
                        ((state_q == EdgeStWrData) && (req_ch != EdgeChW)));

    always_comb begin
        src_d    = src_q;
        axi_id_d = axi_id_q;
        len_d    = len_q;
        beat_d   = beat_q;
        if (offender) begin
            src_d    = req_src_id_i;
            axi_id_d = req_axi_id_i;
            if (req_ch == EdgeChAr) begin
                len_d  = req_len_i;
                beat_d = 8'd0;
            end
        end
        if (state_q == EdgeStRdResp && rsp_ready_i) beat_d = beat_q + 8'd1;
    end

    // An increment coinciding with clr_i starts the fresh record rather than being lost.
    always_comb begin
        cnt_d       = cnt_q;
        err_valid_d = err_valid_q;
        err_src_d   = err_src_q;
        proto_d     = proto_q;
        if (clr_i) begin
            cnt_d       = '0;
            err_valid_d = 1'b0;
            err_src_d   = '0;
            proto_d     = 1'b0;
        end
        if (offender) begin
            if (clr_i) begin
                cnt_d = CntWidth'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CntWidth'(1);
            end
            if (clr_i || !err_valid_q) begin
                err_valid_d = 1'b1;
                err_src_d   = req_src_id_i;
            end
        end
        if (proto_hit) proto_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q       <= '0;
            axi_id_q    <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_src_q   <= '0;
            proto_q     <= 1'b0;
        end else begin
            src_q       <= src_d;
            axi_id_q    <= axi_id_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            err_valid_q <= err_valid_d;
            err_src_q   <= err_src_d;
            proto_q     <= proto_d;
        end
    end

    assign err_cnt_o   = cnt_q;
    assign err_valid_o = err_valid_q;
    assign err_src_o   = err_src_q;
    assign proto_err_o = proto_q;

endmodule

// File: tb/tb_floo_edge_err_responder.sv
// tb/tb_floo_edge_err_responder.sv - scoreboard bench for the mesh-edge error responder
module tb_floo_edge_err_responder;

    localparam int IdW  = 6;
    localparam int AxiW = 4;
    localparam int DW   = 64;
    localparam int CW   = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [1:0]      req_ch_i = 2'd0;
    logic [IdW-1:0]  req_src_id_i = '0;
    logic [AxiW-1:0] req_axi_id_i = '0;
    logic [7:0]      req_len_i = '0;
    logic            req_last_i = 1'b0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic            rsp_ch_o;
    logic [IdW-1:0]  rsp_dst_id_o;
    logic [AxiW-1:0] rsp_axi_id_o;
    logic [1:0]      rsp_resp_o;
    logic [DW-1:0]   rsp_data_o;
    logic            rsp_last_o;
    logic            clr_i = 1'b0;
    logic [CW-1:0]   err_cnt_o;
    logic            err_valid_o;
    logic [IdW-1:0]  err_src_o;
    logic            proto_err_o;

    floo_edge_err_responder #(
        .IdWidth(IdW), .AxiIdWidth(AxiW), .DataWidth(DW), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ch_i(req_ch_i),
        .req_src_id_i(req_src_id_i), .req_axi_id_i(req_axi_id_i), .req_len_i(req_len_i),
        .req_last_i(req_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_ch_o(rsp_ch_o),
        .rsp_dst_id_o(rsp_dst_id_o), .rsp_axi_id_o(rsp_axi_id_o), .rsp_resp_o(rsp_resp_o),
        .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .clr_i(clr_i), .err_cnt_o(err_cnt_o), .err_valid_o(err_valid_o),
        .err_src_o(err_src_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            ch;
        logic [IdW-1:0]  dst;
        logic [AxiW-1:0] id;
        logic            last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    logic                hold_prev = 1'b0;
    logic [IdW+AxiW+3:0] fields_prev = '0;

    always @(negedge clk_i) begin
        exp_t e;
        logic [IdW+AxiW+3:0] fields;
        fields = {rsp_ch_o, rsp_dst_id_o, rsp_axi_id_o, rsp_resp_o, rsp_last_o};
        if (!rst_ni) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {63'd0, rsp_valid_o}, 64'd1);
                check("hold_fields", {{(64-IdW-AxiW-4){1'b0}}, fields},
                      {{(64-IdW-AxiW-4){1'b0}}, fields_prev});
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_ch",   {63'd0, rsp_ch_o}, {63'd0, e.ch});
                    check("rsp_dst",  {{(64-IdW){1'b0}}, rsp_dst_id_o}, {{(64-IdW){1'b0}}, e.dst});
                    check("rsp_id",   {{(64-AxiW){1'b0}}, rsp_axi_id_o}, {{(64-AxiW){1'b0}}, e.id});
                    check("rsp_last", {63'd0, rsp_last_o}, {63'd0, e.last});
                    check("rsp_resp", {62'd0, rsp_resp_o}, 64'd3);
                    check("rsp_data", rsp_data_o, 64'd0);
                end
            end
            hold_prev   = rsp_valid_o && !rsp_ready_i;
            fields_prev = fields;
        end
    end

    task automatic push(input logic ch, input logic [IdW-1:0] dst, input logic [AxiW-1:0] id,
                        input logic last);
        exp_t e;
        e.ch = ch; e.dst = dst; e.id = id; e.last = last;
        sb.push_back(e);
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [1:0] ch, input logic [IdW-1:0] src,
                        input logic [AxiW-1:0] id, input logic [7:0] len, input logic last,
                        input logic clr);
        logic rdy;
        bit   ok;
        ok = 0;
        req_valid_i = 1'b1; req_ch_i = ch; req_src_id_i = src;
        req_axi_id_i = id; req_len_i = len; req_last_i = last; clr_i = clr;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            rdy = req_ready_o;
            @(posedge clk_i);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        req_valid_i = 1'b0; req_last_i = 1'b0; clr_i = 1'b0;
        if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            if (!rsp_valid_o && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("rsp_drain_timeout", 64'd0, 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("rst_rsp_resp",  {62'd0, rsp_resp_o}, 64'd0);
        check("rst_err_cnt",   {56'd0, err_cnt_o}, 64'd0);
        check("rst_err_valid", {63'd0, err_valid_o}, 64'd0);
        check("rst_proto",     {63'd0, proto_err_o}, 64'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // AR len=3: four back-to-back R beats starting the cycle after acceptance
        rsp_ready_i = 1'b1;
        for (int b = 0; b < 4; b++) push(1'b1, 6'h12, 4'd3, b == 3);
        send(2'd2, 6'h12, 4'd3, 8'd3, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_i);
            check("ar_beat_valid", {63'd0, rsp_valid_o}, 64'd1);
        end
        @(negedge clk_i);
        check("ar_after_burst", {63'd0, rsp_valid_o}, 64'd0);
        check("ar_err_cnt",   {56'd0, err_cnt_o}, 64'd1);
        check("ar_err_src",   {58'd0, err_src_o}, 64'h12);
        check("ar_err_valid", {63'd0, err_valid_o}, 64'd1);
        @(posedge clk_i);
        #1;

        // AW + 3 W beats with B stalled by rsp_ready_i=0
        rsp_ready_i = 1'b0;
        send(2'd0, 6'h07, 4'd5, 8'd0, 1'b0, 1'b0);
        send(2'd1, 6'h07, 4'd0, 8'd0, 1'b0, 1'b0);
        send(2'd1, 6'h07, 4'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        check("aw_no_early_b", {63'd0, rsp_valid_o}, 64'd0);
        @(posedge clk_i);
        #1;
        push(1'b0, 6'h07, 4'd5, 1'b1);
        send(2'd1, 6'h07, 4'd0, 8'd0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("b_held_valid", {63'd0, rsp_valid_o}, 64'd1);
            check("b_req_ready",  {63'd0, req_ready_o}, 64'd0);
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        wait_done();
        check("aw_err_cnt", {56'd0, err_cnt_o}, 64'd2);
        check("aw_err_src", {58'd0, err_src_o}, 64'h12);
        check("aw_proto",   {63'd0, proto_err_o}, 64'd0);

        // Stray W in Idle
        send(2'd1, 6'h09, 4'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        check("w_idle_proto", {63'd0, proto_err_o}, 64'd1);
        check("w_idle_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
        check("w_idle_ready", {63'd0, req_ready_o}, 64'd1);
        check("w_idle_cnt",   {56'd0, err_cnt_o}, 64'd2);
        @(posedge clk_i);
        #1;

        // clr_i coincident with AR acceptance
        push(1'b1, 6'h21, 4'd1, 1'b1);
        send(2'd2, 6'h21, 4'd1, 8'd0, 1'b0, 1'b1);
        wait_done();
        check("clr_inc_cnt",   {56'd0, err_cnt_o}, 64'd1);
        check("clr_inc_src",   {58'd0, err_src_o}, 64'h21);
        check("clr_inc_valid", {63'd0, err_valid_o}, 64'd1);
        check("clr_inc_proto", {63'd0, proto_err_o}, 64'd0);

        // Saturation at all-ones (8-bit counter), first offender kept
        for (int i = 0; i < 260; i++) begin
            push(1'b1, 6'h30, 4'd2, 1'b1);
            send(2'd2, 6'h30, 4'd2, 8'd0, 1'b0, 1'b0);
            if (i == 252) check("sat_cnt_253", {56'd0, err_cnt_o}, 64'd254);
        end
        wait_done();
        check("sat_cnt", {56'd0, err_cnt_o}, 64'hFF);
        check("sat_src", {58'd0, err_src_o}, 64'h21);

        // Reset while beat 2 of an 8-beat burst is pending
        rsp_ready_i = 1'b1;
        push(1'b1, 6'h2A, 4'd6, 1'b0);
        push(1'b1, 6'h2A, 4'd6, 1'b0);
        send(2'd2, 6'h2A, 4'd6, 8'd7, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready_o}, 64'd1);
        check("midrst_err_cnt",   {56'd0, err_cnt_o}, 64'd0);
        check("midrst_sb_empty",  sb.size(), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        push(1'b1, 6'h11, 4'd2, 1'b1);
        send(2'd2, 6'h11, 4'd2, 8'd0, 1'b0, 1'b0);
        wait_done();
        check("post_rst_cnt", {56'd0, err_cnt_o}, 64'd1);
        check("final_sb_empty", sb.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
